// File: rtl/simple_source.sv
// Valid/ready byte-stream source emitting an arithmetic byte pattern.
// Define SIMPLE_SOURCE_CHECKSUM_EN to append a two's-complement checksum byte.
module simple_source #(
    parameter int         MSG_LEN    = 16,
    parameter logic [7:0] FIRST_BYTE = 8'h41,
    parameter logic [7:0] STEP       = 8'h01,
    parameter int         GAP        = 0,
    parameter bit         LOOP       = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] dst_data,
    output logic       dst_valid,
    input  logic       dst_ready
);

    localparam int IW = $clog2(MSG_LEN + 1);
`ifdef SIMPLE_SOURCE_CHECKSUM_EN
    localparam int LEN = MSG_LEN + 1;
`else
    localparam int LEN = MSG_LEN;
`endif
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_data;
    logic [7:0]    w_next_data;
    logic          w_xfer;
    logic          w_last;
    logic          w_load;

    assign w_xfer = (r_state == S_SEND) && dst_ready;
    assign w_last = (r_idx == LAST);
    assign w_load = ((r_state == S_IDLE) && start) ||
                    ((r_state == S_DONE) && LOOP);

`ifdef SIMPLE_SOURCE_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_all;

    // Final pattern byte is still in r_data, so fold it into the sum here.
    assign w_sum_all   = r_sum + r_data;
    assign w_next_data = (r_idx == IW'(MSG_LEN - 1)) ?
                         (~w_sum_all + 8'd1) : (r_data + STEP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sum <= 8'd0;
        end else if (w_load) begin
            r_sum <= 8'd0;
        end else if (w_xfer) begin
            r_sum <= w_sum_all;
        end
    end
`else
    assign w_next_data = r_data + STEP;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_SEND;
            S_SEND: begin
                if (w_xfer) begin
                    if (w_last)
                        w_next = S_DONE;
                    else
                        w_next = (GAP > 0) ? S_GAP : S_SEND;
                end
            end
            S_GAP:  if (r_gap == GLAST) w_next = S_SEND;
            S_DONE: w_next = LOOP ? S_SEND : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_gap   <= '0;
            r_data  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_idx  <= '0;
                r_data <= FIRST_BYTE;
            end else if (w_xfer) begin
                r_idx  <= r_idx + 1'b1;
                r_data <= w_next_data;
            end
            if (r_state == S_GAP)
                r_gap <= r_gap + 1'b1;
            else
                r_gap <= '0;
        end
    end

    // All outputs decode registered state, so none depends on dst_ready.
    assign dst_valid = (r_state == S_SEND);
    assign busy      = (r_state == S_SEND) || (r_state == S_GAP);
    assign done      = (r_state == S_DONE);
    assign dst_data  = r_data;

endmodule

// File: tb/tb_simple_source.sv
// Directed self-checking bench for simple_source across several parameter sets.
module tb_simple_source;

`ifdef SIMPLE_SOURCE_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int L0 = 16 + EXTRA;
    localparam int L1 = 3 + EXTRA;
    localparam int L2 = 4 + EXTRA;
    localparam int L4 = 2 + EXTRA;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    logic       start0, busy0, done0, valid0, ready0;
    logic [7:0] data0;
    logic       start1, busy1, done1, valid1, ready1;
    logic [7:0] data1;
    logic       start2, busy2, done2, valid2, ready2;
    logic [7:0] data2;
    logic       start4, busy4, done4, valid4, ready4;
    logic [7:0] data4;

    simple_source u0 (
        .clock(clock), .reset(reset), .start(start0), .busy(busy0),
        .done(done0), .dst_data(data0), .dst_valid(valid0),
        .dst_ready(ready0)
    );

    simple_source #(.MSG_LEN(3), .GAP(2)) u1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1),
        .done(done1), .dst_data(data1), .dst_valid(valid1),
        .dst_ready(ready1)
    );

    simple_source #(.MSG_LEN(4), .FIRST_BYTE(8'hFE), .STEP(8'h01)) u2 (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2),
        .done(done2), .dst_data(data2), .dst_valid(valid2),
        .dst_ready(ready2)
    );

    simple_source #(.MSG_LEN(2), .FIRST_BYTE(8'h30), .STEP(8'h02),
                    .LOOP(1'b1)) u4 (
        .clock(clock), .reset(reset), .start(start4), .busy(busy4),
        .done(done4), .dst_data(data4), .dst_valid(valid4),
        .dst_ready(ready4)
    );

`ifdef SIMPLE_SOURCE_CHECKSUM_EN
    logic       start3, busy3, done3, valid3, ready3;
    logic [7:0] data3;

    simple_source #(.MSG_LEN(2), .FIRST_BYTE(8'h10), .STEP(8'h10)) u3 (
        .clock(clock), .reset(reset), .start(start3), .busy(busy3),
        .done(done3), .dst_data(data3), .dst_valid(valid3),
        .dst_ready(ready3)
    );
`endif

    function automatic logic [7:0] exp_byte(input logic [7:0] f,
                                            input logic [7:0] s,
                                            input int n, input int i);
        logic [7:0] acc;
        logic [7:0] sum;
        acc = f;
        sum = 8'd0;
        for (int k = 0; k < i; k++) begin
            if (k < n) sum = sum + acc;
            acc = acc + s;
        end
        if (i < n) return acc;
        return (~sum) + 8'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int acc;
        int cyc;
        logic r;
        logic [7:0] cs [3];
        cs[0] = 8'h10;
        cs[1] = 8'h20;
        cs[2] = 8'hD0;
        start0 = 0; ready0 = 0;
        start1 = 0; ready1 = 0;
        start2 = 0; ready2 = 0;
        start4 = 0; ready4 = 0;
`ifdef SIMPLE_SOURCE_CHECKSUM_EN
        start3 = 0; ready3 = 0;
`endif
        repeat (2) tick();
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        reset = 1;
        tick();
        chk("idle_valid", 32'(valid0), 32'd0);

        // Full-rate message, start held high part-way to show it is ignored.
        ready0 = 1;
        start0 = 1;
        tick();
        for (int i = 0; i < L0; i++) begin
            chk("run_valid", 32'(valid0), 32'd1);
            chk("run_busy", 32'(busy0), 32'd1);
            chk("run_done", 32'(done0), 32'd0);
            chk("run_data", 32'(data0), 32'(exp_byte(8'h41, 8'h01, 16, i)));
            if (i == 8) start0 = 0;
            tick();
        end
        chk("run_done_hi", 32'(done0), 32'd1);
        chk("run_busy_lo", 32'(busy0), 32'd0);
        chk("run_valid_lo", 32'(valid0), 32'd0);
        tick();
        chk("run_done_pulse", 32'(done0), 32'd0);
        chk("run_idle_valid", 32'(valid0), 32'd0);

        // Random back-pressure.
        ready0 = 0;
        start0 = 1;
        tick();
        start0 = 0;
        acc = 0;
        cyc = 0;
        while (acc < L0 && cyc < 400) begin
            chk("bp_valid", 32'(valid0), 32'd1);
            chk("bp_done", 32'(done0), 32'd0);
            chk("bp_data", 32'(data0), 32'(exp_byte(8'h41, 8'h01, 16, acc)));
            r = 1'($urandom_range(0, 1));
            ready0 = r;
            tick();
            if (r) acc++;
            cyc++;
        end
        if (acc < L0) chk("bp_timeout", 32'(acc), 32'(L0));
        chk("bp_done_hi", 32'(done0), 32'd1);
        ready0 = 0;
        tick();
        chk("bp_done_pulse", 32'(done0), 32'd0);

        // GAP=2: valid, 0, 0, valid, ...
        ready1 = 1;
        start1 = 1;
        tick();
        start1 = 0;
        for (int i = 0; i < L1; i++) begin
            chk("gap_valid", 32'(valid1), 32'd1);
            chk("gap_data", 32'(data1), 32'(exp_byte(8'h41, 8'h01, 3, i)));
            tick();
            if (i < L1 - 1) begin
                for (int g = 0; g < 2; g++) begin
                    chk("gap_idle", 32'(valid1), 32'd0);
                    chk("gap_busy", 32'(busy1), 32'd1);
                    tick();
                end
            end
        end
        chk("gap_done", 32'(done1), 32'd1);

        // 8-bit wrap of the pattern.
        ready2 = 1;
        start2 = 1;
        tick();
        start2 = 0;
        for (int i = 0; i < L2; i++) begin
            chk("wrap_valid", 32'(valid2), 32'd1);
            chk("wrap_data", 32'(data2), 32'(exp_byte(8'hFE, 8'h01, 4, i)));
            tick();
        end
        chk("wrap_done", 32'(done2), 32'd1);

        // Reset while offering byte 5.
        ready0 = 1;
        start0 = 1;
        tick();
        start0 = 0;
        repeat (5) tick();
        chk("mid_data", 32'(data0), 32'h46);
        chk("mid_valid", 32'(valid0), 32'd1);
        reset = 0;
        #1;
        chk("mid_rst_valid", 32'(valid0), 32'd0);
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_data", 32'(data0), 32'd0);
        tick();
        chk("mid_rst_done", 32'(done0), 32'd0);
        #2 reset = 1;
        tick();
        chk("post_rst_valid", 32'(valid0), 32'd0);
        chk("post_rst_done", 32'(done0), 32'd0);
        start0 = 1;
        tick();
        start0 = 0;
        chk("restart_data", 32'(data0), 32'h41);
        chk("restart_valid", 32'(valid0), 32'd1);
        repeat (L0) tick();
        chk("restart_done", 32'(done0), 32'd1);
        ready0 = 0;

`ifdef SIMPLE_SOURCE_CHECKSUM_EN
        // Checksum byte, start held through the busy period.
        ready3 = 1;
        start3 = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("cs_valid", 32'(valid3), 32'd1);
            chk("cs_data", 32'(data3), 32'(cs[i]));
            if (i == 2) start3 = 0;
            tick();
        end
        chk("cs_done", 32'(done3), 32'd1);
        tick();
        chk("cs_idle", 32'(valid3), 32'd0);
`endif

        // LOOP=1 restarts without a new start pulse.
        ready4 = 1;
        start4 = 1;
        tick();
        start4 = 0;
        for (int i = 0; i < L4; i++) begin
            chk("loop_data", 32'(data4), 32'(exp_byte(8'h30, 8'h02, 2, i)));
            tick();
        end
        chk("loop_done", 32'(done4), 32'd1);
        chk("loop_busy_lo", 32'(busy4), 32'd0);
        ready4 = 0;
        tick();
        chk("loop_valid", 32'(valid4), 32'd1);
        chk("loop_data0", 32'(data4), 32'h30);
        chk("loop_busy", 32'(busy4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
